memory_bist_fsm: RTL and testbench

Parametrised built-in self-test engine for the dual-port block RAM. It writes a selectable data pattern over an address window through port A, reads the window back through port B, and compares every word against the expected pattern. It reports busy/done/pass, a saturating error count and the first failing address. It replaces the fixed six-step memory demo FSM and drives the same BRAM ports and 7-segment display select.

---
 rtl/memory_bist_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_memory_bist_fsm.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bist_fsm.sv
// memory_bist_fsm: built-in self-test engine for the dual-port block RAM.
// A run writes a selectable pattern over [START_ADDR, END_ADDR] through port A, reads
// the window back through port B and compares each returned word with the pattern.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a run (honoured only in IDLE or DONE)
//   pattern_sel     0: k, 1: ~k, 2: checkerboard, 3: walking one (captured on start)
//   dataOutA/B      BRAM read data (only port B is checked)
//   weA/B, addressA/B, dataInA/B   BRAM port controls
//   displaySelect   0 = show port A, 1 = show port B
//   busy, done, pass, errorCount, firstErrorAddr   run status
module memory_bist_fsm #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned START_ADDR   = 0,
  parameter int unsigned END_ADDR     = 1023,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] dataOutA,
  input  logic [DATA_WIDTH-1:0] dataOutB,
  output logic                  weA,
  output logic                  weB,
  output logic [ADDR_WIDTH-1:0] addressA,
  output logic [ADDR_WIDTH-1:0] addressB,
  output logic [DATA_WIDTH-1:0] dataInA,
  output logic [DATA_WIDTH-1:0] dataInB,
  output logic                  displaySelect,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           errorCount,
  output logic [ADDR_WIDTH-1:0] firstErrorAddr
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_ADDR);

  localparam int unsigned DCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(READ_LATENCY - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DCW-1:0]        drain_q, drain_d;
  logic [1:0]            pat_q;
  logic                  accept;

  // Issued read addresses travel alongside the BRAM latency; the last stage
  // identifies which address the word currently on dataOutB belongs to.
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [ADDR_WIDTH-1:0]   pipe_addr_q [READ_LATENCY];

  logic                  cmp_en;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic                  mismatch;

  logic unused_dataouta;
  assign unused_dataouta = ^dataOutA;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0]            sel,
                                                    input logic [ADDR_WIDTH-1:0] k);
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] kx;
    logic [DATA_WIDTH-1:0]            kd;
    logic [DATA_WIDTH-1:0]            cb;
    kx = {{DATA_WIDTH{1'b0}}, k};
    kd = kx[DATA_WIDTH-1:0];
    // Even k -> odd bits set (0xAA..), odd k -> even bits set (0x55..).
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      cb[i] = ((i % 2) == 1) ^ k[0];
    end
    unique case (sel)
      2'd0:    pattern = kd;
      2'd1:    pattern = ~kd;
      2'd2:    pattern = cb;
      default: pattern = DATA_WIDTH'(1) << (32'(k) % DATA_WIDTH);
    endcase
  endfunction

  // Next-state and address counter; the counter is reloaded rather than
  // incremented at END_A so it can never wrap mid-phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_WRITE;
          cnt_d   = START_A;
        end
      end
      ST_WRITE: begin
        if (cnt_q == END_A) begin
          state_d = ST_READ;
          cnt_d   = START_A;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_READ: begin
        if (cnt_q == END_A) begin
          state_d = ST_DRAIN;
          cnt_d   = START_A;
          drain_d = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      if (accept) pat_q <= pattern_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) pipe_addr_q[i] <= '0;
    end else begin
      pipe_vld_q[0]  <= (state_q == ST_READ);
      pipe_addr_q[0] <= cnt_q;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

  assign cmp_en   = pipe_vld_q[READ_LATENCY-1];
  assign cmp_addr = pipe_addr_q[READ_LATENCY-1];
  assign mismatch = cmp_en && (dataOutB != pattern(pat_q, cmp_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errorCount     <= '0;
      firstErrorAddr <= '0;
    end else if (accept) begin
      errorCount     <= '0;
      firstErrorAddr <= '0;
    end else if (mismatch) begin
      if (errorCount == '0) firstErrorAddr <= cmp_addr;
      if (errorCount != 16'hFFFF) errorCount <= errorCount + 16'd1;
    end
  end

  always_comb begin
    weA           = 1'b0;
    weB           = 1'b0;
    addressA      = '0;
    addressB      = '0;
    dataInA       = '0;
    dataInB       = '0;
    displaySelect = 1'b0;
    case (state_q)
      ST_WRITE: begin
        weA      = 1'b1;
        addressA = cnt_q;
        dataInA  = pattern(pat_q, cnt_q);
      end
      ST_READ: begin
        addressB      = cnt_q;
        displaySelect = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);
  assign pass = (state_q == ST_DONE) && (errorCount == '0);

endmodule

// File: tb/tb_memory_bist_fsm.sv
module tb_memory_bist_fsm;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int SA = 10;
  localparam int EA = 15;
  localparam int RL = 2;
  localparam int N  = EA - SA + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic [DW-1:0] dataOutA, dataOutB;
  logic          weA, weB, displaySelect, busy, done, pass;
  logic [AW-1:0] addressA, addressB, firstErrorAddr;
  logic [DW-1:0] dataInA, dataInB;
  logic [15:0]   errorCount;

  always #5 clk = ~clk;

  memory_bist_fsm #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_ADDR(SA), .END_ADDR(EA), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pattern_sel(pattern_sel),
    .dataOutA(dataOutA), .dataOutB(dataOutB),
    .weA(weA), .weB(weB), .addressA(addressA), .addressB(addressB),
    .dataInA(dataInA), .dataInB(dataInB), .displaySelect(displaySelect),
    .busy(busy), .done(done), .pass(pass),
    .errorCount(errorCount), .firstErrorAddr(firstErrorAddr)
  );

  // BRAM model: synchronous write on A, RL-cycle read on B, per-address fault masks.
  logic [DW-1:0] mem    [16];
  logic [DW-1:0] and_m  [16];
  logic [DW-1:0] xor_m  [16];
  logic [DW-1:0] rpipe  [RL];

  always @(posedge clk) begin
    if (weA) mem[addressA] <= dataInA;
    rpipe[0] <= (mem[addressB] & and_m[addressB]) ^ xor_m[addressB];
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign dataOutB = rpipe[RL-1];
  assign dataOutA = mem[addressA];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
  endtask

  function automatic logic [15:0] ref_pat(input int sel, input int k);
    case (sel)
      0:       return 16'(k);
      1:       return ~16'(k);
      2:       return (k % 2 == 0) ? 16'hAAAA : 16'h5555;
      default: return 16'(1) << (k % 16);
    endcase
  endfunction

  typedef struct {int errs; int first; int edge_n;} exp_t;
  typedef struct {int a; int d;} wr_t;

  exp_t exp_q [$];
  wr_t  wr_q  [$];
  int   rd_q  [$];

  // Monitor: pops the scoreboard whenever the DUT writes, reads or finishes.
  logic done_prev = 1'b0;
  exp_t me;
  wr_t  mw;
  int   mr;
  always @(negedge clk) begin
    if (!rst) begin
      chk("weB_low", longint'(weB), 0);
      if (weA) begin
        if (wr_q.size() == 0) flag("unexpected_write");
        else begin
          mw = wr_q.pop_front();
          chk("write_addr", longint'(addressA), mw.a);
          chk("write_data", longint'(dataInA), mw.d);
        end
      end
      if (displaySelect) begin
        if (rd_q.size() == 0) flag("unexpected_read");
        else begin
          mr = rd_q.pop_front();
          chk("read_addr", longint'(addressB), mr);
        end
      end
      if (done && !done_prev) begin
        if (exp_q.size() == 0) flag("unexpected_done");
        else begin
          me = exp_q.pop_front();
          chk("done_edge", cyc, me.edge_n);
          chk("errorCount", longint'(errorCount), me.errs);
          chk("firstErrorAddr", longint'(firstErrorAddr), me.first);
          chk("pass", longint'(pass), (me.errs == 0) ? 1 : 0);
          chk("busy_at_done", longint'(busy), 0);
        end
      end
    end
    done_prev <= done;
  end

  int exp_errs, exp_first;

  task automatic set_faults(input int fmode);
    int fa;
    for (int a = 0; a < 16; a++) begin
      and_m[a] = 16'hFFFF;
      xor_m[a] = 16'h0000;
    end
    case (fmode)
      1: begin
        fa = $urandom_range(SA, EA);
        and_m[fa] = 16'h0000;
      end
      2: for (int a = 0; a < 16; a++) and_m[a] = 16'hFFFE;
      3: for (int a = SA; a <= EA; a++)
           if ($urandom_range(0, 2) == 0) xor_m[a] = 16'($urandom_range(1, 16'hFFFF));
      default: ;
    endcase
  endtask

  // Reference: the memory holds the pattern, the read path applies the fault masks.
  task automatic compute_expect(input int pat);
    logic [15:0] w, r;
    exp_errs  = 0;
    exp_first = 0;
    for (int k = SA; k <= EA; k++) begin
      w = ref_pat(pat, k);
      r = (w & and_m[k]) ^ xor_m[k];
      if (r != w) begin
        if (exp_errs == 0) exp_first = k;
        exp_errs++;
      end
    end
  endtask

  task automatic push_traffic(input int pat);
    wr_t w;
    for (int k = SA; k <= EA; k++) begin
      w.a = k;
      w.d = int'(ref_pat(pat, k));
      wr_q.push_back(w);
    end
    for (int k = SA; k <= EA; k++) rd_q.push_back(k);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!done) flag(name);
  endtask

  task automatic hold_check();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    chk("hold_done", longint'(done), 1);
    chk("hold_errorCount", longint'(errorCount), exp_errs);
    chk("hold_firstErrorAddr", longint'(firstErrorAddr), exp_first);
    chk("hold_pass", longint'(pass), (exp_errs == 0) ? 1 : 0);
    chk("hold_no_write", longint'(weA), 0);
  endtask

  task automatic run_test(input int pat, input int fmode, input bit hold);
    exp_t e;
    int   acc;
    set_faults(fmode);
    compute_expect(pat);
    push_traffic(pat);
    @(negedge clk);
    acc      = cyc + 1;
    e.errs   = exp_errs;
    e.first  = exp_first;
    e.edge_n = acc + 2 * N + RL;
    exp_q.push_back(e);
    if (hold) begin
      push_traffic(pat);
      e.edge_n = acc + 2 * (2 * N + RL) + 1;
      exp_q.push_back(e);
    end
    pattern_sel = 2'(pat);
    start = 1'b1;
    @(negedge clk);
    chk("busy_after_start", longint'(busy), 1);
    chk("done_cleared", longint'(done), 0);
    if (hold) begin
      wait_done("done_timeout_hold");
      @(negedge clk);
      chk("restart_busy", longint'(busy), 1);
      chk("restart_done", longint'(done), 0);
      chk("restart_errorCount", longint'(errorCount), 0);
      start = 1'b0;
    end else begin
      start = 1'b0;
      repeat ($urandom_range(1, 2 * N - 2)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("done_timeout");
    hold_check();
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ctrl"}, longint'({weA, weB, displaySelect, busy, done, pass}), 0);
    chk({name, "_addr_data"}, longint'({addressA, addressB, dataInA, dataInB}), 0);
    chk({name, "_status"}, longint'({errorCount, firstErrorAddr}), 0);
  endtask

  task automatic reset_mid_read();
    int t = 0;
    set_faults(2);
    pattern_sel = 2'd1;
    push_traffic(1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!displaySelect && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!displaySelect) flag("read_phase_timeout");
    repeat ($urandom_range(1, 3)) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("midrun_reset");
    wr_q.delete();
    rd_q.delete();
    exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset_busy", longint'(busy), 0);
  endtask

  initial begin
    for (int a = 0; a < 16; a++) begin
      mem[a]   = 16'($urandom);
      and_m[a] = 16'hFFFF;
      xor_m[a] = 16'h0000;
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);

    run_test(0, 0, 1'b0);  // ideal memory, address pattern
    run_test(3, 1, 1'b0);  // one address reads back zero
    run_test(1, 2, 1'b0);  // bit 0 stuck at zero
    run_test(2, 0, 1'b0);  // checkerboard, clean
    reset_mid_read();
    run_test(2, 0, 1'b0);  // clean rerun after reset
    run_test(0, 1, 1'b1);  // start held high: restart from DONE
    for (int i = 0; i < 8; i++) run_test($urandom_range(0, 3), $urandom_range(0, 3), 1'b0);

    repeat (3) @(negedge clk);
    chk("writes_drained", wr_q.size(), 0);
    chk("reads_drained", rd_q.size(), 0);
    chk("results_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
